// File: rtl/mu0_run_controller.sv
// mu0_run_controller
// This block owns the MU0 memory bus for one CPU run. It holds the CPU in
// reset, writes the program image into memory, resets the CPU for one cycle,
// then hands the bus to the CPU. It finishes when the CPU halts (done) or
// when the run-cycle budget is used up (error).
module mu0_run_controller #(
    parameter int unsigned MAX_CYCLES = 1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        load_valid_i,
    output logic        load_ready_o,
    input  logic [15:0] load_data_i,
    input  logic        load_last_i,
    output logic        cpu_rst_o,
    input  logic        cpu_running_i,
    input  logic [11:0] cpu_address_i,
    input  logic        cpu_read_i,
    input  logic        cpu_write_i,
    input  logic [15:0] cpu_writedata_i,
    output logic [15:0] cpu_readdata_o,
    output logic [11:0] mem_address_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [15:0] mem_writedata_o,
    input  logic [15:0] mem_readdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [12:0] words_loaded_o,
    output logic [31:0] cycles_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RESET_CPU,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [31:0] MAX_C     = 32'(MAX_CYCLES);
    localparam logic [12:0] LAST_ADDR = 13'd4095;

    state_e      state_q, state_d;
    logic [12:0] words_q, words_d;
    logic [31:0] cycles_q, cycles_d;
    logic        load_ready_q;
    logic        cpu_rst_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic        run_q;
    logic        load_fire;

    // The write happens in the same cycle that the handshake completes.
    // load_ready_q is a register, so there is no path from load_valid to load_ready.
    assign load_fire = load_ready_q && load_valid_i;

    // Next-state and counter update. The word count also serves as the load
    // address. Neither counter can wrap, because the FSM leaves the state
    // before the limit would be passed.
    always_comb begin
        state_d  = state_q;
        words_d  = words_q;
        cycles_d = cycles_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d  = S_LOAD;
                    words_d  = '0;
                    cycles_d = '0;
                end
            end
            S_LOAD: begin
                if (load_valid_i) begin
                    words_d = words_q + 13'd1;
                    // A write to 0xFFF fills the image, so it counts as the last word.
                    if (load_last_i || (words_q == LAST_ADDR)) begin
                        state_d = S_RESET_CPU;
                    end
                end
            end
            S_RESET_CPU: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cpu_running_i) begin
                    cycles_d = cycles_q + 32'd1;
                    if ((cycles_q + 32'd1) == MAX_C) begin
                        state_d = S_ERROR;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and the registered flags. The flags are decoded from
    // the next state, so they change on the same edge as the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            words_q      <= '0;
            cycles_q     <= '0;
            load_ready_q <= 1'b0;
            cpu_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_q      <= words_d;
            cycles_q     <= cycles_d;
            load_ready_q <= (state_d == S_LOAD);
            cpu_rst_q    <= (state_d == S_IDLE) || (state_d == S_LOAD) ||
                            (state_d == S_RESET_CPU);
            busy_q       <= (state_d == S_LOAD) || (state_d == S_RESET_CPU) ||
                            (state_d == S_RUN);
            done_q       <= (state_d == S_DONE);
            error_q      <= (state_d == S_ERROR);
            run_q        <= (state_d == S_RUN);
        end
    end

    // Memory bus mux. In RUN the CPU drives the bus directly.
    // In every other state the controller drives it, and the only access
    // it makes is a LOAD write. An asynchronous reset clears run_q, which
    // cuts the CPU off the bus at once.
    always_comb begin
        mem_address_o   = words_q[11:0];
        mem_read_o      = 1'b0;
        mem_write_o     = load_fire;
        mem_writedata_o = load_ready_q ? load_data_i : 16'h0000;
        if (run_q) begin
            mem_address_o   = cpu_address_i;
            mem_read_o      = cpu_read_i;
            mem_write_o     = cpu_write_i;
            mem_writedata_o = cpu_writedata_i;
        end
    end

    assign cpu_readdata_o = mem_readdata_i;
    assign load_ready_o   = load_ready_q;
    assign cpu_rst_o      = cpu_rst_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign words_loaded_o = words_q;
    assign cycles_o       = cycles_q;

endmodule

// File: tb/tb_mu0_run_controller.sv
// Testbench for mu0_run_controller. The bench emulates the CPU and the
// memory. It applies random program images and random run lengths, and it
// checks every cycle against a reference model that counts words and cycles.
`timescale 1ns/1ps
module tb_mu0_run_controller;

    localparam int MAXC = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic        load_last;
    logic        cpu_rst;
    logic        cpu_running;
    logic [11:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_writedata;
    logic [15:0] cpu_readdata;
    logic [11:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_writedata;
    logic [15:0] mem_readdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [12:0] words_loaded;
    logic [31:0] cycles;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mem [4096];
    logic [15:0] img [4096];

    always #5 clk = ~clk;

    mu0_run_controller #(.MAX_CYCLES(MAXC)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .load_valid_i    (load_valid),
        .load_ready_o    (load_ready),
        .load_data_i     (load_data),
        .load_last_i     (load_last),
        .cpu_rst_o       (cpu_rst),
        .cpu_running_i   (cpu_running),
        .cpu_address_i   (cpu_address),
        .cpu_read_i      (cpu_read),
        .cpu_write_i     (cpu_write),
        .cpu_writedata_i (cpu_writedata),
        .cpu_readdata_o  (cpu_readdata),
        .mem_address_o   (mem_address),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .mem_writedata_o (mem_writedata),
        .mem_readdata_i  (mem_readdata),
        .busy_o          (busy),
        .done_o          (done),
        .error_o         (error),
        .words_loaded_o  (words_loaded),
        .cycles_o        (cycles)
    );

    // Single-port memory model: synchronous write, read data valid the next cycle.
    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_writedata;
        if (mem_read)  mem_readdata <= mem[mem_address];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " cpu_rst"},       cpu_rst,       1);
        check_eq({tag, " load_ready"},    load_ready,    0);
        check_eq({tag, " busy"},          busy,          0);
        check_eq({tag, " done"},          done,          0);
        check_eq({tag, " error"},         error,         0);
        check_eq({tag, " mem_read"},      mem_read,      0);
        check_eq({tag, " mem_write"},     mem_write,     0);
        check_eq({tag, " mem_address"},   mem_address,   0);
        check_eq({tag, " mem_writedata"}, mem_writedata, 0);
        check_eq({tag, " words_loaded"},  words_loaded,  0);
        check_eq({tag, " cycles"},        cycles,        0);
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("start load_ready", load_ready, 1);
        check_eq("start busy", busy, 1);
        check_eq("start done", done, 0);
        check_eq("start error", error, 0);
        check_eq("start words", words_loaded, 0);
        check_eq("start cycles", cycles, 0);
        check_eq("start cpu_rst", cpu_rst, 1);
        $display("start: load begun");
    endtask

    // Stream img[0..len-1] into the controller and check every write as it happens.
    task automatic do_load(input int len, input bit use_last, input bit gaps);
        int idx;
        int guard;
        bit v;
        idx = 0;
        guard = 0;
        while (idx < len && guard < 20000) begin
            @(posedge clk); #1;
            v          = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            load_valid = v;
            load_data  = img[idx];
            load_last  = use_last && (idx == len - 1);
            start      = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            check_eq("load load_ready", load_ready, 1);
            check_eq("load busy", busy, 1);
            check_eq("load cpu_rst", cpu_rst, 1);
            check_eq("load words", words_loaded, idx);
            check_eq("load mem_write", mem_write, v);
            check_eq("load mem_read", mem_read, 0);
            if (v) begin
                check_eq("load addr", mem_address, idx);
                check_eq("load data", mem_writedata, img[idx]);
                idx++;
            end
            guard++;
        end
        if (guard >= 20000) check_eq("load timeout", 0, 1);
        // RESET_CPU cycle. A further word is offered here and must be refused.
        @(posedge clk); #1;
        load_valid = 1'b1;
        load_last  = 1'b0;
        load_data  = 16'($urandom);
        start      = 1'b0;
        @(negedge clk);
        check_eq("rstcpu load_ready", load_ready, 0);
        check_eq("rstcpu mem_write", mem_write, 0);
        check_eq("rstcpu cpu_rst", cpu_rst, 1);
        check_eq("rstcpu busy", busy, 1);
        check_eq("rstcpu words", words_loaded, len);
        for (int i = 0; i < len; i++) check_eq("image word", mem[i], img[i]);
        $display("load: %0d words, last=%0b gaps=%0b", len, use_last, gaps);
    endtask

    // Let the emulated CPU run for n cycles with running=1, then halt.
    task automatic do_run(input int n);
        int  r;
        bit  exp_err;
        r = (n < MAXC) ? n + 1 : MAXC;
        for (int k = 0; k < r; k++) begin
            @(posedge clk); #1;
            load_valid    = 1'b0;
            cpu_running   = (k < n);
            cpu_address   = 12'($urandom);
            cpu_read      = 1'($urandom);
            cpu_write     = 1'($urandom);
            cpu_writedata = 16'($urandom);
            start         = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            check_eq("run cpu_rst", cpu_rst, 0);
            check_eq("run busy", busy, 1);
            check_eq("run cycles", cycles, k);
            check_eq("run addr", mem_address, cpu_address);
            check_eq("run read", mem_read, cpu_read);
            check_eq("run write", mem_write, cpu_write);
            check_eq("run wdata", mem_writedata, cpu_writedata);
            check_eq("run rdata", cpu_readdata, mem_readdata);
        end
        exp_err = (n >= MAXC);
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            start       = 1'b0;
            cpu_running = 1'($urandom);
            cpu_read    = 1'b1;
            cpu_write   = 1'b1;
            @(negedge clk);
            check_eq("end done", done, !exp_err);
            check_eq("end error", error, exp_err);
            check_eq("end busy", busy, 0);
            check_eq("end cpu_rst", cpu_rst, 0);
            check_eq("end cycles", cycles, exp_err ? MAXC : n);
            check_eq("end mem_read", mem_read, 0);
            check_eq("end mem_write", mem_write, 0);
            check_eq("end load_ready", load_ready, 0);
        end
        $display("run: n=%0d cycles=%0d done=%0b error=%0b", n, cycles, done, error);
    endtask

    initial begin
        int len;
        int n;
        rst_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        cpu_running = 1'b0; cpu_address = 12'h5A5; cpu_read = 1'b1; cpu_write = 1'b1;
        cpu_writedata = 16'hBEEF; mem_readdata = '0;
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0;
        $display("reset: power-on values checked");

        // Reset mid-LOAD with load_valid high. The outputs must return with no clock edge.
        do_start();
        @(posedge clk); #1;
        load_valid = 1'b1; load_data = 16'h1234;
        @(posedge clk); #1;
        load_data = 16'h5678;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midload");
        load_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: mid-load checked");

        // Reset mid-RUN. The CPU must be cut off the bus at once.
        img[0] = 16'h7000;
        do_start();
        do_load(1, 1'b1, 1'b0);
        @(posedge clk); #1;
        load_valid = 1'b0; cpu_running = 1'b1; cpu_read = 1'b1; cpu_write = 1'b1;
        @(negedge clk);
        check_eq("midrun pre mem_write", mem_write, 1);
        rst_n = 1'b0;
        #1;
        check_eq("midrun mem_read", mem_read, 0);
        check_eq("midrun mem_write", mem_write, 0);
        check_eq("midrun cpu_rst", cpu_rst, 1);
        @(negedge clk);
        rst_n = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_running = 1'b0;
        $display("reset: mid-run checked");

        // Random images and run lengths, including budget overrun and the last cycle before it.
        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) img[i] = 16'($urandom);
            if (it == 1)           n = MAXC - 1;
            else if (it == 2)      n = MAXC;
            else if (it % 3 == 0)  n = $urandom_range(MAXC, MAXC + 20);
            else                   n = $urandom_range(1, MAXC - 2);
            do_start();
            do_load(len, 1'b1, 1'b1);
            do_run(n);
        end

        // Full 4096-word image with no load_last.
        for (int i = 0; i < 4096; i++) img[i] = 16'($urandom);
        do_start();
        do_load(4096, 1'b0, 1'b0);
        do_run(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
